// File: rtl/rx_port_arbiter_250_pkg.sv
// Shared AXIS field widths, per-beat record and arbiter state type for the
// 250 MHz packet-filter RX path.
package packet_filter_pkg;

    localparam int AXIS_DATA_W = 512;
    localparam int AXIS_KEEP_W = 64;
    localparam int AXIS_USER_W = 16;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0] tdata;
        logic [AXIS_KEEP_W-1:0] tkeep;
        logic                   tlast;
        logic [AXIS_USER_W-1:0] size;
        logic [AXIS_USER_W-1:0] src;
        logic [AXIS_USER_W-1:0] dst;
    } axis_beat_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Port-index width; a single port still needs a 1-bit index.
    function automatic int port_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rx_port_arbiter_250_axis_rr_select.sv
// Cyclic first-one search: finds the first set request at or after i_ptr,
// wrapping past the top port back to port 0.
module axis_rr_select #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic         o_found,
    output logic [W-1:0] o_idx
);

    localparam logic [W:0] NUM = (W+1)'(N);

    logic [2*N-1:0] w_req_dbl;
    logic [N-1:0]   w_req_rot;
    logic [W:0]     w_sum;

    // Rotating the doubled vector puts the pointer's port at bit 0.
    assign w_req_dbl = {i_req, i_req};
    assign w_req_rot = N'(w_req_dbl >> i_ptr);

    always_comb begin
        o_found = 1'b0;
        w_sum   = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                o_found = 1'b1;
                w_sum   = {1'b0, i_ptr} + (W+1)'(i);
            end
        end
        o_idx = (w_sum >= NUM) ? W'(w_sum - NUM) : W'(w_sum);
    end

endmodule

// File: rtl/rx_port_arbiter_250.sv
// Packet-granular round-robin merge of the CMAC adapter RX streams into one
// registered AXIS stream, tagged with the source port, with per-port counts.
module rx_port_arbiter_250
    import packet_filter_pkg::*;
#(
    parameter int DATA_WIDTH    = AXIS_DATA_W,
    parameter int KEEP_WIDTH    = AXIS_KEEP_W,
    parameter int NUM_CMAC_PORT = 2,
    parameter int PORT_W        = port_idx_w(NUM_CMAC_PORT)
) (
    input  logic                               axis_aclk,
    input  logic                               box_rstn,
    input  logic [NUM_CMAC_PORT-1:0]           s_axis_adap_rx_250mhz_tvalid,
    input  logic [NUM_CMAC_PORT-1:0]           s_axis_adap_rx_250mhz_tlast,
    output logic [NUM_CMAC_PORT-1:0]           s_axis_adap_rx_250mhz_tready,
    input  logic [DATA_WIDTH*NUM_CMAC_PORT-1:0] s_axis_adap_rx_250mhz_tdata,
    input  logic [KEEP_WIDTH*NUM_CMAC_PORT-1:0] s_axis_adap_rx_250mhz_tkeep,
    input  logic [16*NUM_CMAC_PORT-1:0]        s_axis_adap_rx_250mhz_tuser_size,
    input  logic [16*NUM_CMAC_PORT-1:0]        s_axis_adap_rx_250mhz_tuser_src,
    input  logic [16*NUM_CMAC_PORT-1:0]        s_axis_adap_rx_250mhz_tuser_dst,
    output logic                               m_axis_tvalid,
    output logic                               m_axis_tlast,
    input  logic                               m_axis_tready,
    output logic [DATA_WIDTH-1:0]              m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]              m_axis_tkeep,
    output logic [15:0]                        m_axis_tuser_size,
    output logic [15:0]                        m_axis_tuser_src,
    output logic [15:0]                        m_axis_tuser_dst,
    output logic [PORT_W-1:0]                  m_axis_port_id,
    input  logic [NUM_CMAC_PORT-1:0]           port_enable,
    output logic                               busy,
    output logic [32*NUM_CMAC_PORT-1:0]        pkt_count
);

    localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NUM_CMAC_PORT - 1);

    arb_state_t              r_state;
    arb_state_t              w_state_next;
    logic [PORT_W-1:0]       r_grant;
    logic [PORT_W-1:0]       r_rr_ptr;
    logic [PORT_W-1:0]       r_port_id;
    logic [PORT_W-1:0]       w_sel_idx;
    logic                    w_sel_found;
    logic [NUM_CMAC_PORT-1:0] w_req;
    axis_beat_t              w_port_beat [NUM_CMAC_PORT];
    axis_beat_t              w_beat;
    axis_beat_t              r_out;
    logic                    r_m_tvalid;
    logic                    w_slot_free;
    logic                    w_accept;
    logic                    w_done;

    for (genvar p = 0; p < NUM_CMAC_PORT; p++) begin : gen_beat
        assign w_port_beat[p] = {s_axis_adap_rx_250mhz_tdata[p*DATA_WIDTH +: DATA_WIDTH],
                                 s_axis_adap_rx_250mhz_tkeep[p*KEEP_WIDTH +: KEEP_WIDTH],
                                 s_axis_adap_rx_250mhz_tlast[p],
                                 s_axis_adap_rx_250mhz_tuser_size[p*16 +: 16],
                                 s_axis_adap_rx_250mhz_tuser_src[p*16 +: 16],
                                 s_axis_adap_rx_250mhz_tuser_dst[p*16 +: 16]};
    end

    assign w_req       = s_axis_adap_rx_250mhz_tvalid & port_enable;
    assign w_beat      = w_port_beat[r_grant];
    assign w_slot_free = !r_m_tvalid || m_axis_tready;
    assign w_accept    = (r_state == BUSY) && s_axis_adap_rx_250mhz_tvalid[r_grant] && w_slot_free;
    assign w_done      = w_accept && w_beat.tlast;

    axis_rr_select #(
        .N (NUM_CMAC_PORT),
        .W (PORT_W)
    ) u_rr_select (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_found (w_sel_found),
        .o_idx   (w_sel_idx)
    );

    always_comb begin
        s_axis_adap_rx_250mhz_tready = '0;
        if (r_state == BUSY) begin
            s_axis_adap_rx_250mhz_tready[r_grant] = w_slot_free;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_sel_found) w_state_next = BUSY;
            BUSY: if (w_done)      w_state_next = IDLE;
        endcase
    end

    // Grant is only re-evaluated in IDLE, so a packet always finishes on its port.
    always_ff @(posedge axis_aclk or negedge box_rstn) begin
        if (!box_rstn) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && w_sel_found) begin
                r_grant <= w_sel_idx;
            end
            if (w_done) begin
                r_rr_ptr <= (r_grant == LAST_PORT) ? '0 : r_grant + 1'b1;
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge box_rstn) begin
        if (!box_rstn) begin
            r_out      <= '0;
            r_port_id  <= '0;
            r_m_tvalid <= 1'b0;
        end else if (w_accept) begin
            r_out      <= w_beat;
            r_port_id  <= r_grant;
            r_m_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    for (genvar p = 0; p < NUM_CMAC_PORT; p++) begin : gen_port
        logic [31:0] r_pkt_count;

        always_ff @(posedge axis_aclk or negedge box_rstn) begin
            if (!box_rstn) begin
                r_pkt_count <= '0;
            end else if (w_done && r_grant == PORT_W'(p)) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
        end

        assign pkt_count[p*32 +: 32] = r_pkt_count;
    end

    assign m_axis_tvalid     = r_m_tvalid;
    assign m_axis_tlast      = r_out.tlast;
    assign m_axis_tdata      = r_out.tdata;
    assign m_axis_tkeep      = r_out.tkeep;
    assign m_axis_tuser_size = r_out.size;
    assign m_axis_tuser_src  = r_out.src;
    assign m_axis_tuser_dst  = r_out.dst;
    assign m_axis_port_id    = r_port_id;
    assign busy              = (r_state == BUSY);

endmodule

// File: tb/tb_rx_port_arbiter_250.sv
// Self-checking bench for rx_port_arbiter_250: directed timing/stall/reset/mask
// scenarios plus random traffic checked against per-port packet queues.
module tb_rx_port_arbiter_250;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam int NP = 2;
    localparam int PW = 1;

    typedef logic [639:0] vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [15:0]   size;
        logic [15:0]   src;
        logic [15:0]   dst;
    } beat_t;

    logic              axis_aclk;
    logic              box_rstn;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tlast;
    logic [NP-1:0]     s_tready;
    logic [DW*NP-1:0]  s_tdata;
    logic [KW*NP-1:0]  s_tkeep;
    logic [16*NP-1:0]  s_size;
    logic [16*NP-1:0]  s_src;
    logic [16*NP-1:0]  s_dst;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic [15:0]       m_axis_tuser_size;
    logic [15:0]       m_axis_tuser_src;
    logic [15:0]       m_axis_tuser_dst;
    logic [PW-1:0]     m_axis_port_id;
    logic [NP-1:0]     port_enable;
    logic              busy;
    logic [32*NP-1:0]  pkt_count;

    beat_t       txq  [NP][$];
    beat_t       expq [NP][$];
    int          outOrder[$];
    logic [31:0] expCount [NP];
    int          errors = 0;
    int          checks = 0;
    int          readyMode;
    bit          readyForce;
    bit          gapEn;

    rx_port_arbiter_250 #(
        .DATA_WIDTH    (DW),
        .KEEP_WIDTH    (KW),
        .NUM_CMAC_PORT (NP)
    ) dut (
        .axis_aclk                        (axis_aclk),
        .box_rstn                         (box_rstn),
        .s_axis_adap_rx_250mhz_tvalid     (s_tvalid),
        .s_axis_adap_rx_250mhz_tlast      (s_tlast),
        .s_axis_adap_rx_250mhz_tready     (s_tready),
        .s_axis_adap_rx_250mhz_tdata      (s_tdata),
        .s_axis_adap_rx_250mhz_tkeep      (s_tkeep),
        .s_axis_adap_rx_250mhz_tuser_size (s_size),
        .s_axis_adap_rx_250mhz_tuser_src  (s_src),
        .s_axis_adap_rx_250mhz_tuser_dst  (s_dst),
        .m_axis_tvalid                    (m_axis_tvalid),
        .m_axis_tlast                     (m_axis_tlast),
        .m_axis_tready                    (m_axis_tready),
        .m_axis_tdata                     (m_axis_tdata),
        .m_axis_tkeep                     (m_axis_tkeep),
        .m_axis_tuser_size                (m_axis_tuser_size),
        .m_axis_tuser_src                 (m_axis_tuser_src),
        .m_axis_tuser_dst                 (m_axis_tuser_dst),
        .m_axis_port_id                   (m_axis_port_id),
        .port_enable                      (port_enable),
        .busy                             (busy),
        .pkt_count                        (pkt_count)
    );

    initial begin
        axis_aclk = 1'b0;
        forever #5 axis_aclk = ~axis_aclk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input vec_t obs, input vec_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic vec_t packBeat(input beat_t b);
        return vec_t'({b.data, b.keep, b.last, b.size, b.src, b.dst});
    endfunction

    // Queues one packet of nBeats random beats on port p and books it as owed.
    task automatic applyStimulus(input int p, input int nBeats);
        beat_t b;
        for (int i = 0; i < nBeats; i++) begin
            for (int w = 0; w < DW/32; w++) b.data[w*32 +: 32] = $urandom;
            b.keep = {$urandom, $urandom};
            b.last = (i == nBeats - 1);
            b.size = 16'(nBeats * 64);
            b.src  = 16'($urandom);
            b.dst  = 16'($urandom);
            txq[p].push_back(b);
            expq[p].push_back(b);
        end
        expCount[p] = expCount[p] + 32'd1;
    endtask

    task automatic waitDrain(input string tag, input int budget);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(negedge axis_aclk);
            done = (txq[0].size() == 0) && (txq[1].size() == 0) &&
                   (expq[0].size() == 0) && (expq[1].size() == 0) &&
                   !m_axis_tvalid && !busy;
            n++;
        end
        checkOutput(tag, vec_t'(done), vec_t'(1));
    endtask

    task automatic checkCounts(input string tag);
        for (int p = 0; p < NP; p++) begin
            checkOutput(tag, vec_t'(pkt_count[p*32 +: 32]), vec_t'(expCount[p]));
        end
    endtask

    // Source-side drivers: hold a beat until accepted, pop on handshake.
    initial begin
        logic [NP-1:0] hs;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_size   = '0;
        s_src    = '0;
        s_dst    = '0;
        m_axis_tready = 1'b1;
        forever begin
            @(negedge axis_aclk);
            hs = s_tvalid & s_tready;
            @(posedge axis_aclk);
            #1;
            case (readyMode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ($urandom_range(3, 0) != 0);
                default: m_axis_tready = readyForce;
            endcase
            for (int p = 0; p < NP; p++) begin
                if (!box_rstn) begin
                    s_tvalid[p] = 1'b0;
                end else begin
                    if (hs[p] && txq[p].size() > 0) void'(txq[p].pop_front());
                    if (s_tvalid[p] && !hs[p]) begin
                        s_tvalid[p] = 1'b1;
                    end else if (txq[p].size() > 0 && (!gapEn || $urandom_range(3, 0) != 0)) begin
                        s_tdata[p*DW +: DW] = txq[p][0].data;
                        s_tkeep[p*KW +: KW] = txq[p][0].keep;
                        s_tlast[p]          = txq[p][0].last;
                        s_size[p*16 +: 16]  = txq[p][0].size;
                        s_src[p*16 +: 16]   = txq[p][0].src;
                        s_dst[p*16 +: 16]   = txq[p][0].dst;
                        s_tvalid[p]         = 1'b1;
                    end else begin
                        s_tvalid[p] = 1'b0;
                    end
                end
            end
        end
    end

    // Output monitor: every delivered beat must be the next owed beat of its port.
    initial begin
        int   port;
        int   curPort;
        bit   inPkt;
        bit   prevLast;
        bit   stalled;
        vec_t held;
        vec_t snap;
        curPort  = 0;
        inPkt    = 1'b0;
        prevLast = 1'b0;
        stalled  = 1'b0;
        held     = '0;
        forever begin
            @(negedge axis_aclk);
            if (!box_rstn) begin
                inPkt    = 1'b0;
                prevLast = 1'b0;
                stalled  = 1'b0;
                continue;
            end
            snap = vec_t'({m_axis_tvalid, m_axis_port_id, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                           m_axis_tuser_size, m_axis_tuser_src, m_axis_tuser_dst});
            if (stalled) checkOutput("stallHold", snap, held);
            if (prevLast && readyMode == 0) checkOutput("bubble", vec_t'(m_axis_tvalid), vec_t'(0));
            prevLast = 1'b0;
            if (m_axis_tvalid && !m_axis_tready) begin
                checkOutput("stallTready", vec_t'(s_tready), vec_t'(0));
                stalled = 1'b1;
                held    = snap;
            end else begin
                stalled = 1'b0;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                port = int'(m_axis_port_id);
                if (inPkt) checkOutput("noInterleave", vec_t'(port), vec_t'(curPort));
                checkOutput("beatOwed", vec_t'(expq[port].size() > 0), vec_t'(1));
                if (expq[port].size() > 0) begin
                    checkOutput("beatData",
                                vec_t'({m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                                        m_axis_tuser_size, m_axis_tuser_src, m_axis_tuser_dst}),
                                packBeat(expq[port].pop_front()));
                end
                if (m_axis_tlast) begin
                    outOrder.push_back(port);
                    inPkt    = 1'b0;
                    prevLast = 1'b1;
                end else begin
                    inPkt   = 1'b1;
                    curPort = port;
                end
            end
        end
    end

    initial begin
        int          n;
        logic [31:0] b0;
        logic [31:0] b1;
        box_rstn    = 1'b0;
        port_enable = 2'b11;
        readyMode   = 0;
        readyForce  = 1'b1;
        gapEn       = 1'b0;
        for (int p = 0; p < NP; p++) expCount[p] = '0;

        repeat (3) @(negedge axis_aclk);
        checkOutput("rstTvalid", vec_t'(m_axis_tvalid), vec_t'(0));
        checkOutput("rstBusy", vec_t'(busy), vec_t'(0));
        checkOutput("rstTready", vec_t'(s_tready), vec_t'(0));
        checkOutput("rstPortId", vec_t'(m_axis_port_id), vec_t'(0));
        checkOutput("rstCount", vec_t'(pkt_count), vec_t'(0));
        checkOutput("rstData", vec_t'({m_axis_tdata, m_axis_tkeep, m_axis_tuser_size,
                                       m_axis_tuser_src, m_axis_tuser_dst}), vec_t'(0));
        @(posedge axis_aclk);
        #2 box_rstn = 1'b1;

        $display("[TB] single 3-beat packet on port 0");
        applyStimulus(0, 3);
        n = 0;
        @(negedge axis_aclk);
        while (!s_tvalid[0] && n < 10) begin
            @(negedge axis_aclk);
            n++;
        end
        checkOutput("t1TvalidSeen", vec_t'(s_tvalid[0]), vec_t'(1));
        checkOutput("t1C0Tvalid", vec_t'(m_axis_tvalid), vec_t'(0));
        checkOutput("t1C0Busy", vec_t'(busy), vec_t'(0));
        @(negedge axis_aclk);
        checkOutput("t1C1Tvalid", vec_t'(m_axis_tvalid), vec_t'(0));
        checkOutput("t1C1Busy", vec_t'(busy), vec_t'(1));
        @(negedge axis_aclk);
        checkOutput("t1C2Beat", vec_t'({m_axis_tvalid, m_axis_tlast, m_axis_port_id}), vec_t'(3'b100));
        @(negedge axis_aclk);
        checkOutput("t1C3Beat", vec_t'({m_axis_tvalid, m_axis_tlast, busy}), vec_t'(3'b101));
        @(negedge axis_aclk);
        checkOutput("t1C4Beat", vec_t'({m_axis_tvalid, m_axis_tlast, m_axis_port_id}), vec_t'(3'b110));
        @(negedge axis_aclk);
        checkOutput("t1C5Tvalid", vec_t'(m_axis_tvalid), vec_t'(0));
        checkOutput("t1C5Busy", vec_t'(busy), vec_t'(0));
        checkOutput("t1C5Count", vec_t'(pkt_count[31:0]), vec_t'(32'd1));

        $display("[TB] back-pressure 1,0,0,1 mid-packet");
        readyMode  = 2;
        readyForce = 1'b1;
        applyStimulus(0, 4);
        n = 0;
        @(negedge axis_aclk);
        while (!m_axis_tvalid && n < 20) begin
            @(negedge axis_aclk);
            n++;
        end
        checkOutput("t2FirstBeat", vec_t'(m_axis_tvalid), vec_t'(1));
        readyForce = 1'b0;
        @(negedge axis_aclk);
        @(negedge axis_aclk);
        readyForce = 1'b1;
        waitDrain("t2Drain", 50);
        checkCounts("t2Count");
        readyMode = 0;

        $display("[TB] reset asserted mid-packet");
        applyStimulus(1, 6);
        n = 0;
        @(negedge axis_aclk);
        while (!m_axis_tvalid && n < 20) begin
            @(negedge axis_aclk);
            n++;
        end
        checkOutput("t3MidPkt", vec_t'({m_axis_tvalid, busy}), vec_t'(2'b11));
        #2 box_rstn = 1'b0;
        #1;
        checkOutput("t3AsyncTvalid", vec_t'(m_axis_tvalid), vec_t'(0));
        checkOutput("t3AsyncTready", vec_t'(s_tready), vec_t'(0));
        checkOutput("t3AsyncBusy", vec_t'(busy), vec_t'(0));
        checkOutput("t3AsyncCount", vec_t'(pkt_count), vec_t'(0));
        for (int p = 0; p < NP; p++) begin
            txq[p].delete();
            expq[p].delete();
            expCount[p] = '0;
        end
        repeat (2) @(negedge axis_aclk);
        @(posedge axis_aclk);
        #2 box_rstn = 1'b1;

        $display("[TB] both ports busy with 2-beat packets");
        outOrder.delete();
        applyStimulus(0, 2);
        applyStimulus(1, 2);
        applyStimulus(0, 2);
        applyStimulus(1, 2);
        waitDrain("t4Drain", 60);
        checkOutput("t4OrderLen", vec_t'(outOrder.size()), vec_t'(4));
        for (int i = 0; i < 4 && i < outOrder.size(); i++) begin
            checkOutput("t4Order", vec_t'(outOrder[i]), vec_t'(i % 2));
        end
        checkCounts("t4Count");

        $display("[TB] port mask 2'b10 then cleared mid-packet");
        outOrder.delete();
        b0 = expCount[0];
        b1 = expCount[1];
        port_enable = 2'b10;
        applyStimulus(0, 3);
        applyStimulus(1, 4);
        applyStimulus(1, 4);
        n = 0;
        @(negedge axis_aclk);
        while (!m_axis_tvalid && n < 20) begin
            @(negedge axis_aclk);
            n++;
        end
        checkOutput("t5FirstGrant", vec_t'({m_axis_tvalid, m_axis_port_id}), vec_t'(2'b11));
        port_enable = 2'b00;
        repeat (30) @(negedge axis_aclk);
        checkOutput("t5OrderLen", vec_t'(outOrder.size()), vec_t'(1));
        if (outOrder.size() > 0) checkOutput("t5OrderPort", vec_t'(outOrder[0]), vec_t'(1));
        checkOutput("t5Idle", vec_t'({busy, m_axis_tvalid}), vec_t'(0));
        checkOutput("t5Count0", vec_t'(pkt_count[31:0]), vec_t'(b0));
        checkOutput("t5Count1", vec_t'(pkt_count[63:32]), vec_t'(b1 + 32'd1));
        port_enable = 2'b11;
        waitDrain("t5Drain", 100);
        checkCounts("t5Count");

        $display("[TB] packet counter wrap on port 1");
        force dut.gen_port[1].r_pkt_count = 32'hFFFF_FFFF;
        @(negedge axis_aclk);
        release dut.gen_port[1].r_pkt_count;
        @(negedge axis_aclk);
        checkOutput("t6Forced", vec_t'(pkt_count[63:32]), vec_t'(32'hFFFF_FFFF));
        expCount[1] = 32'hFFFF_FFFF;
        applyStimulus(1, 2);
        waitDrain("t6Drain", 40);
        checkOutput("t6WrapZero", vec_t'(pkt_count[63:32]), vec_t'(0));
        checkCounts("t6Count");

        $display("[TB] random traffic with random back-pressure and source gaps");
        readyMode = 1;
        gapEn     = 1'b1;
        for (int k = 0; k < 30; k++) begin
            applyStimulus($urandom_range(NP - 1, 0), $urandom_range(5, 1));
            repeat ($urandom_range(4, 0)) @(negedge axis_aclk);
        end
        waitDrain("t7Drain", 3000);
        checkCounts("t7Count");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
